lc4_mul_recombiner: RTL and testbench
=====================================

# lc4_mul_recombiner

Sequential shift-add unit computing `quotient * divisor + remainder` over 16-bit LC4 words, the inverse of `lc4_divider`. It rebuilds a dividend from divider outputs. It sits beside the divider in the datapath test and self-check infrastructure, and reports when the full result does not fit in 16 bits. Radix-2, one multiplier bit per cycle, with a start/done handshake.

## Interface
- Parameters: none; the word width is fixed at 16 bits (LC4 word).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  request; sampled only in IDLE or DONE.
- `i_quotient`  in  16  multiplier operand; captured on the accepting edge.
- `i_divisor`  in  16  multiplicand operand; captured on the accepting edge.
- `i_remainder`  in  16  addend; captured on the accepting edge.
- `o_busy`  out  1  high while in RUN.
- `o_done`  out  1  one-cycle pulse; result valid.
- `o_dividend`  out  16  low 16 bits of the result, held until the next completion.
- `o_overflow`  out  1  high when result bits [31:16] are nonzero; held like `o_dividend`.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- Reset values: `o_busy`=0, `o_done`=0, `o_dividend`=0x0000, `o_overflow`=0. All internal registers are cleared.
- Accept: when the state is IDLE or DONE and `i_start`=1 at an edge, the block loads:
  - acc[31:0] = {16'h0, i_remainder}
  - mcand[31:0] = {16'h0, i_divisor}
  - mplier[15:0] = i_quotient
  - count = 0
  - next state = RUN
- RUN, each edge:
  - if mplier[0], acc = acc + mcand (32-bit add, no carry-out possible);
  - mcand <<= 1; mplier >>= 1; count++.
  - After the 16th iteration (count reaches 16), the next state is DONE.
  - On that same edge, `o_dividend` = acc[15:0] and `o_overflow` = |acc[31:16]; both are registered from the final acc value.
- DONE lasts one cycle with `o_done`=1. The next state is IDLE, or RUN if `i_start`=1 (back-to-back requests are allowed).
- `i_start` in RUN is ignored. Operands must be stable only at the accepting edge.
- Arithmetic bound: the maximum result is 0xFFFF*0xFFFF + 0xFFFF = 0xFFFF0000, so 32 bits never overflow.
- Division by zero: operand values are not special-cased. Divisor 0 yields the remainder.
- Reset asserted mid-operation: the block returns to IDLE immediately (asynchronously), all outputs go to their reset values, and the partial result is discarded. No `o_done` is produced for the aborted request.

## Timing
- Edge 0 is the edge that accepts `i_start`.
- `o_busy` is high from after edge 0 until edge N.
- `o_done`, `o_dividend` and `o_overflow` update at edge N; `o_done` is high for exactly one cycle.
- N = 16 by default. N under the configuration option is defined in Configuration.
- Throughput: one result per N+1 cycles when requests are issued back-to-back from DONE.
- There is no combinational path from inputs to outputs.

## Configuration
- `LC4_MUL_EARLY_EXIT_EN`
- Defined: in RUN, the block moves to DONE on the edge where the shifted mplier becomes 0 or count reaches 16. This gives N = max(1, bit length of `i_quotient`). A quotient of 0 gives N=1; 0x0005 gives N=3.
- Undefined: always N=16.
- Results are identical either way; only latency differs.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0. Release and idle 20 cycles → `o_done` never pulses.
- Basic: q=0x0123, d=0x00E1, r=0x0007 → `o_dividend`=0xFFCA, `o_overflow`=0, `o_done` at edge 16 (without the macro).
- Overflow: q=0xFFFF, d=0xFFFF, r=0xFFFF → `o_dividend`=0x0000, `o_overflow`=1. Then q=0x0100, d=0x0100, r=0 → 0x0000 with overflow=1.
- Handshake:
  - pulse `i_start` at edge 5 of a busy operation → ignored, and the first result is correct;
  - assert `i_start` during the DONE cycle with q=3, d=4, r=2 → second `o_done` 16 edges later with 0x000E.
- Mid-operation reset: drop `rst_n` between edges 8 and 9 → outputs 0 immediately and no `o_done`. After release, q=7, d=9, r=1 → 0x0040.
- Early exit (macro defined):
  - q=0x0005, d=0x0003, r=0x0001 → 0x0010 at edge 3;
  - q=0, d=0x1234, r=0x0042 → 0x0042 at edge 1;
  - q=0x8000, d=2, r=0 → 0x0000, overflow=1, at edge 16.
  - Without the macro, all of these complete at edge 16 with the same values.
- Random self-check against `lc4_divider`: 1000 random pairs with nonzero divisor, feed the divider's q/r back in → `o_dividend` equals the original dividend and `o_overflow`=0.

Source files
------------

// File: rtl/lc4_mul_recombiner.sv
// lc4_mul_recombiner
//   Radix-2 shift-add unit that rebuilds a dividend from divider outputs:
//   result = quotient * divisor + remainder over 16-bit LC4 words.
//   One multiplier bit is consumed per cycle. Start/done handshake.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   i_start      in   request, sampled only in IDLE or DONE
//   i_quotient   in   [15:0] multiplier, captured on the accepting edge
//   i_divisor    in   [15:0] multiplicand, captured on the accepting edge
//   i_remainder  in   [15:0] addend, captured on the accepting edge
//   o_busy       out  high while iterating
//   o_done       out  one-cycle pulse, result valid
//   o_dividend   out  [15:0] low half of the result, held until next completion
//   o_overflow   out  result bits [31:16] nonzero, held like o_dividend
//
// Configuration
//   LC4_MUL_EARLY_EXIT_EN  finish as soon as the remaining multiplier bits are
//                          all zero (latency = max(1, bit length of quotient)).
//                          Results are identical; only latency changes.

module lc4_mul_recombiner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_quotient,
  input  logic [15:0] i_divisor,
  input  logic [15:0] i_remainder,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_dividend,
  output logic        o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] dividend_q, dividend_d;
  logic        overflow_q, overflow_d;

  // One iteration's worth of arithmetic, shared by next-state and datapath.
  logic [31:0] acc_step;
  logic [31:0] mcand_step;
  logic [15:0] mplier_step;
  logic [4:0]  count_step;
  logic        last_iter;
  logic        accept;

  always_comb begin
    acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_step  = mcand_q << 1;
    mplier_step = mplier_q >> 1;
    count_step  = count_q + 5'd1;
`ifdef LC4_MUL_EARLY_EXIT_EN
    // Once no multiplier bits remain, further iterations add nothing.
    last_iter   = (count_step == 5'd16) || (mplier_step == '0);
`else
    last_iter   = (count_step == 5'd16);
`endif
    accept      = i_start && (state_q != S_RUN);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = i_start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    count_d    = count_q;
    dividend_d = dividend_q;
    overflow_d = overflow_q;
    if (accept) begin
      acc_d    = {16'h0000, i_remainder};
      mcand_d  = {16'h0000, i_divisor};
      mplier_d = i_quotient;
      count_d  = '0;
    end else if (state_q == S_RUN) begin
      acc_d    = acc_step;
      mcand_d  = mcand_step;
      mplier_d = mplier_step;
      count_d  = count_step;
      // Result registers take the post-add value on the final edge.
      if (last_iter) begin
        dividend_d = acc_step[15:0];
        overflow_d = |acc_step[31:16];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      dividend_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      count_q    <= count_d;
      dividend_q <= dividend_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs: all from registers, no input-to-output path.
  always_comb begin
    o_busy     = (state_q == S_RUN);
    o_done     = (state_q == S_DONE);
    o_dividend = dividend_q;
    o_overflow = overflow_q;
  end

endmodule

// File: tb/tb_lc4_mul_recombiner.sv
module tb_lc4_mul_recombiner;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_quotient;
  logic [15:0] i_divisor;
  logic [15:0] i_remainder;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_dividend;
  logic        o_overflow;

  int errors = 0;
  int checks = 0;

  lc4_mul_recombiner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_quotient (i_quotient),
    .i_divisor  (i_divisor),
    .i_remainder(i_remainder),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_dividend (o_dividend),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected completion edge, counted from the accepting edge.
  function automatic int exp_lat(input logic [15:0] q);
    int bl;
    bl = 0;
    for (int i = 0; i < 16; i++) if (q[i]) bl = i + 1;
`ifdef LC4_MUL_EARLY_EXIT_EN
    return (bl == 0) ? 1 : bl;
`else
    return (bl >= 0) ? 16 : 16;
`endif
  endfunction

  // Reference: plain integer arithmetic.
  function automatic logic [31:0] model(input logic [15:0] q, d, r);
    longint unsigned v;
    v = longint'(q) * longint'(d) + longint'(r);
    return v[31:0];
  endfunction

  // Issue one request (from IDLE or DONE) and check latency, busy and result.
  // Returns at #1 after the completion edge.
  task automatic run_op(input logic [15:0] q, d, r, input string tag);
    logic [31:0] full;
    int          n, k;
    bit          busy_ok;
    full = model(q, d, r);
    n    = exp_lat(q);
    i_quotient = q; i_divisor = d; i_remainder = r; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    // Scramble operands: they must have been captured at the accepting edge.
    i_quotient = 16'($urandom); i_divisor = 16'($urandom); i_remainder = 16'($urandom);
    k = 0; busy_ok = 1'b1;
    while (!o_done && k < 40) begin
      if (!o_busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (o_done !== 1'b1) begin
      errors++; $display("FAIL %s.timeout: no o_done within 40 edges", tag);
    end
    checks++;
    if (k !== n) begin
      errors++; $display("FAIL %s.latency: got %0d expected %0d", tag, k, n);
    end
    checks++;
    if (busy_ok !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL %s.busy: busy_ok=%0d busy_at_done=%0d expected 1/0", tag, busy_ok, o_busy);
    end
    checks++;
    if (o_dividend !== full[15:0]) begin
      errors++; $display("FAIL %s.dividend: got %h expected %h", tag, o_dividend, full[15:0]);
    end
    checks++;
    if (o_overflow !== (|full[31:16])) begin
      errors++; $display("FAIL %s.overflow: got %b expected %b", tag, o_overflow, |full[31:16]);
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0; i_start = 1'b0;
    i_quotient = '0; i_divisor = '0; i_remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_dividend, o_overflow} !== 19'h0) begin
      errors++;
      $display("FAIL reset.outputs: got busy=%b done=%b div=%h ovf=%b expected all 0",
               o_busy, o_done, o_dividend, o_overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_done || o_busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL reset.idle: got %0d active cycles expected 0", pulses);
    end
  endtask

  task automatic test_basic();
    bit hold_ok;
    run_op(16'h0123, 16'h00E1, 16'h0007, "basic");
    checks++;
    if (o_dividend !== 16'hFFCA) begin
      errors++; $display("FAIL basic.const: got %h expected FFCA", o_dividend);
    end
    hold_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_dividend !== 16'hFFCA) hold_ok = 1'b0;
    end
    checks++;
    if (hold_ok !== 1'b1) begin
      errors++; $display("FAIL basic.hold: got done=%b div=%h expected 0/FFCA held", o_done, o_dividend);
    end
  endtask

  task automatic test_overflow();
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, "ovf_max");
    checks++;
    if ({o_overflow, o_dividend} !== 17'h1_0000) begin
      errors++; $display("FAIL ovf_max.const: got ovf=%b div=%h expected 1/0000", o_overflow, o_dividend);
    end
    repeat (2) @(posedge clk);
    #1;
    run_op(16'h0100, 16'h0100, 16'h0000, "ovf_pow2");
  endtask

  task automatic test_start_ignored();
    logic [31:0] full;
    int k;
    full = model(16'h8421, 16'h0013, 16'h0005);
    i_quotient = 16'h8421; i_divisor = 16'h0013; i_remainder = 16'h0005; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // Now just after edge 4: this pulse is seen at edge 5 while busy.
    i_quotient = 16'h0001; i_divisor = 16'h0001; i_remainder = 16'h0001; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    k = 5;
    while (!o_done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k !== 16) begin
      errors++; $display("FAIL ignore.latency: got %0d expected 16", k);
    end
    checks++;
    if (o_dividend !== full[15:0] || o_overflow !== (|full[31:16])) begin
      errors++; $display("FAIL ignore.result: got %h/%b expected %h/%b",
                         o_dividend, o_overflow, full[15:0], |full[31:16]);
    end
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL ignore.idle: got busy=%b done=%b expected 0/0", o_busy, o_done);
    end
  endtask

  task automatic test_back_to_back();
    run_op(16'h0ABC, 16'h0011, 16'h0003, "b2b_first");
    // Still in the DONE cycle: the next request is accepted on the next edge.
    run_op(16'h0003, 16'h0004, 16'h0002, "b2b_second");
    checks++;
    if (o_dividend !== 16'h000E) begin
      errors++; $display("FAIL b2b.const: got %h expected 000E", o_dividend);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    i_quotient = 16'hFFFF; i_divisor = 16'h1111; i_remainder = 16'h0003; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_dividend, o_overflow} !== 19'h0) begin
      errors++;
      $display("FAIL midreset.outputs: got busy=%b done=%b div=%h ovf=%b expected all 0",
               o_busy, o_done, o_dividend, o_overflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_done || o_busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midreset.nodone: got %0d active cycles expected 0", seen);
    end
    run_op(16'h0007, 16'h0009, 16'h0001, "after_reset");
    checks++;
    if (o_dividend !== 16'h0040) begin
      errors++; $display("FAIL after_reset.const: got %h expected 0040", o_dividend);
    end
  endtask

  task automatic test_early_exit();
    run_op(16'h0005, 16'h0003, 16'h0001, "ee_q5");
    run_op(16'h0000, 16'h1234, 16'h0042, "ee_q0");
    run_op(16'h8000, 16'h0002, 16'h0000, "ee_q8000");
    run_op(16'h0001, 16'h0000, 16'hBEEF, "ee_div0");
  endtask

  task automatic test_random_divider();
    logic [15:0] dvd, d, q, r;
    for (int i = 0; i < 1000; i++) begin
      dvd = 16'($urandom);
      d   = (i % 2 == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 255));
      q   = dvd / d;
      r   = dvd % d;
      run_op(q, d, r, "rand_div");
      checks++;
      if (o_dividend !== dvd || o_overflow !== 1'b0) begin
        errors++; $display("FAIL rand_div.roundtrip: got %h/%b expected %h/0 (q=%h d=%h r=%h)",
                           o_dividend, o_overflow, dvd, q, d, r);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_random_general();
    for (int i = 0; i < 150; i++) begin
      run_op(16'($urandom), 16'($urandom), 16'($urandom), "rand_gen");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    test_early_exit();
    test_random_divider();
    test_random_general();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
